// File: rtl/data_bus_sync.sv
// data_bus_sync: enable-qualified (MCP) multi-bit CDC receiver.
// A data-valid level from the source domain goes through a flop chain. The
// rising edge of the chain output loads the held-stable source bus into a
// destination-domain register and produces a one-cycle strobe.
module data_bus_sync #(
    parameter int WIDTH            = 8,
    parameter int FLIP_FLOP_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] unsync_bus,
    input  logic             bus_enable,
    output logic [WIDTH-1:0] sync_bus,
    output logic             enable_pulse_reg
);

    logic [FLIP_FLOP_STAGES-1:0] r_sync_stages;
    logic                        r_pulse_ff;
    logic [WIDTH-1:0]            r_sync_bus;
    logic                        r_enable_pulse;
    logic                        w_sync_en;
    logic                        w_enable_pulse;

    // Shift the asynchronous enable through the metastability chain; stage 0 samples the raw input
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync_stages <= '0;
        end else begin
            r_sync_stages <= {r_sync_stages[FLIP_FLOP_STAGES-2:0], bus_enable};
        end
    end

    assign w_sync_en = r_sync_stages[FLIP_FLOP_STAGES-1];

    // Remember the previous synchronized enable so only its rising edge produces a load
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pulse_ff <= 1'b0;
        end else begin
            r_pulse_ff <= w_sync_en;
        end
    end

    assign w_enable_pulse = w_sync_en & ~r_pulse_ff;

    // Capture the stable source bus on the edge-detect pulse and register the strobe alongside it
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync_bus     <= '0;
            r_enable_pulse <= 1'b0;
        end else begin
            r_enable_pulse <= w_enable_pulse;
            if (w_enable_pulse) begin
                r_sync_bus <= unsync_bus;
            end
        end
    end

    assign sync_bus         = r_sync_bus;
    assign enable_pulse_reg = r_enable_pulse;

endmodule

// File: tb/tb_data_bus_sync.sv
// tb_data_bus_sync: directed bench for data_bus_sync with a three-stage chain.
// Inputs change and outputs are sampled just after the falling clock edge, so
// the next rising edge is the first one to see any new input.
module tb_data_bus_sync;

    localparam int WIDTH  = 8;
    localparam int STAGES = 3;

    logic             CLK;
    logic             RST;
    logic [WIDTH-1:0] unsync_bus;
    logic             bus_enable;
    logic [WIDTH-1:0] sync_bus;
    logic             enable_pulse_reg;

    int compared   = 0;
    int mismatched = 0;

    data_bus_sync #(
        .WIDTH            (WIDTH),
        .FLIP_FLOP_STAGES (STAGES)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .unsync_bus       (unsync_bus),
        .bus_enable       (bus_enable),
        .sync_bus         (sync_bus),
        .enable_pulse_reg (enable_pulse_reg)
    );

    // Free-running destination clock, 10 time units per period
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive the source-domain inputs
    task automatic applyStimulus(input logic en, input logic [WIDTH-1:0] bus);
        bus_enable = en;
        unsync_bus = bus;
    endtask

    // Advance one full clock cycle, ending just after the falling edge
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Compare both outputs against the expected values
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] expBus, input logic expPulse);
        compared++;
        assert (sync_bus === expBus) else begin
            mismatched++;
            $error("[TB] FAIL %s sync_bus: observed %h expected %h", tag, sync_bus, expBus);
        end
        compared++;
        assert (enable_pulse_reg === expPulse) else begin
            mismatched++;
            $error("[TB] FAIL %s enable_pulse_reg: observed %b expected %b", tag, enable_pulse_reg, expPulse);
        end
    endtask

    // Linear directed sequence
    initial begin
        RST = 1'b1;
        applyStimulus(1'b1, 8'hFF);

        // Reset asserted asynchronously with enable high and an all-ones bus
        #2 RST = 1'b0;
        #1 checkOutput("reset_immediate", 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("reset_held", 8'h00, 1'b0);
        end

        // Release reset with the enable low and let things settle
        applyStimulus(1'b0, 8'h00);
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("post_reset_idle", 8'h00, 1'b0);
        end

        // First capture: outputs change only on the fourth rising edge
        applyStimulus(1'b1, 8'b10101010);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("cap1_latency", 8'h00, 1'b0);
        end
        tick();
        checkOutput("cap1_load", 8'b10101010, 1'b1);
        tick();
        checkOutput("cap1_pulse_end", 8'b10101010, 1'b0);

        // Hold: enable low, bus changes are ignored
        applyStimulus(1'b0, 8'b11111111);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hold", 8'b10101010, 1'b0);
        end

        // Second capture after the chain has drained
        applyStimulus(1'b1, 8'b10101110);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("cap2_latency", 8'b10101010, 1'b0);
        end
        tick();
        checkOutput("cap2_load", 8'b10101110, 1'b1);

        // Long enable: keep it high for 20 more cycles while the bus changes
        applyStimulus(1'b1, 8'h55);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("long_enable", 8'b10101110, 1'b0);
            if (i == 10) applyStimulus(1'b1, 8'h3C);
        end

        // Drop the enable and let the chain drain
        applyStimulus(1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("drain", 8'b10101110, 1'b0);
        end

        // Reset two edges after the enable rises: the in-flight enable is discarded
        applyStimulus(1'b1, 8'hC3);
        tick();
        tick();
        applyStimulus(1'b0, 8'hC3);
        RST = 1'b0;
        #1 checkOutput("midreset_immediate", 8'h00, 1'b0);
        tick();
        RST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("midreset_after", 8'h00, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/data_bus_sync.md
Name: data_bus_sync

Overview:
Multi-bit clock-domain-crossing synchronizer. It uses the enable-qualified (MCP) scheme.
- A single-bit bus_enable from the source domain passes through a FLIP_FLOP_STAGES-deep flop chain.
- The chain output is converted to a one-cycle pulse.
- That pulse loads the stable source bus into the destination-domain register.
- It sits at the receive side of any crossing where a data bus travels with a qualifying enable.

Parameters:
WIDTH, 8, bit width of unsync_bus / sync_bus.
FLIP_FLOP_STAGES, 2, number of synchronizer flops on bus_enable; legal range >= 2. Benches use 3.

Ports:
CLK  input  1  destination-domain clock; all state updates on its rising edge.
RST  input  1  reset.
unsync_bus  input  WIDTH  data bus from source domain; sender holds it stable while bus_enable is high.
bus_enable  input  1  asynchronous data-valid level from source domain.
sync_bus  output  WIDTH  synchronized, registered data.
enable_pulse_reg  output  1  registered one-CLK-cycle pulse marking the cycle sync_bus takes a new value.

Interface (already decided): one clock; reset is asynchronous and active-low. Clock port is CLK, reset port is RST. RST low clears all state immediately, independent of CLK.

Behaviour:
- Reset (RST=0, async): clear every flop to 0.
  - This covers all sync chain stages, the pulse-generator flop, sync_bus (all zeros) and enable_pulse_reg (0).
  - Reset deassertion needs no special handling beyond normal flop release.
- Sync chain:
  - stage[0] <= bus_enable.
  - stage[i] <= stage[i-1] for i = 1 .. FLIP_FLOP_STAGES-1.
  - sync_en = stage[FLIP_FLOP_STAGES-1].
- Pulse generator:
  - pulse_ff <= sync_en.
  - enable_pulse (combinational) = sync_en & ~pulse_ff, i.e. the rising-edge detect of sync_en.
- Output registers:
  - enable_pulse_reg <= enable_pulse.
  - sync_bus <= enable_pulse ? unsync_bus : sync_bus (hold otherwise).
- Latency: bus_enable rises before rising edge E1. Then:
  - sync_en goes high after edge E(FLIP_FLOP_STAGES).
  - sync_bus is updated and enable_pulse_reg goes high after edge E(FLIP_FLOP_STAGES+1).
  - With FLIP_FLOP_STAGES=3, outputs are valid within 4 CLK periods of the enable rising.
- Pulse width: enable_pulse_reg is high exactly one CLK cycle per bus_enable rising edge. This holds regardless of how long bus_enable stays high.
- bus_enable low: sync_bus holds its last loaded value; unsync_bus changes are ignored.
- bus_enable held high continuously: one load only. Later unsync_bus changes are not captured until bus_enable falls and rises again.
- Re-arm: a new pulse needs bus_enable low long enough to propagate through the chain, i.e. sync_en must be observed low for at least one cycle.
- Glitch shorter than one CLK period on bus_enable: may or may not be captured. Either result must give a clean single pulse or none; never two pulses.
- Mid-operation reset: discards any in-flight enable. Outputs return to 0 and no pulse is produced for the discarded enable after release.
- Data bus bits are not individually synchronized. Correctness relies on unsync_bus being stable from before bus_enable rises until after enable_pulse_reg.

Test Plan:
1. Reset: RST=0 with bus_enable=1 and unsync_bus=8'hFF -> sync_bus=8'h00 and enable_pulse_reg=0 immediately, and they stay so while RST=0.
2. Capture: after reset, unsync_bus=8'b10101010 with bus_enable=1 (FLIP_FLOP_STAGES=3) -> sync_bus=8'b10101010 and enable_pulse_reg=1 exactly 4 edges later. enable_pulse_reg=0 on the next cycle.
3. Hold: bus_enable=0 and unsync_bus=8'b11111111 -> sync_bus stays 8'b10101010 and no pulse, over at least 4 cycles.
4. Second capture: bus_enable=1 with unsync_bus=8'b10101110 -> sync_bus=8'b10101110 with a single one-cycle pulse after 4 edges.
5. Long enable: bus_enable held high for 20 cycles while unsync_bus changes after the load -> exactly one pulse, and sync_bus keeps the first captured value.
6. Reset mid-flight: RST pulsed low 2 edges after bus_enable rises -> no pulse follows, and sync_bus=0.
